// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic operand feeder and its buffers.
package systolic_pkg;

   localparam int DEF_DATA_W = 8;

   localparam logic WSEL_A = 1'b0;
   localparam logic WSEL_B = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/operand_buf.sv
// Row-major operand tile storage: one write port, NRD combinational read ports.
module operand_buf
   import systolic_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 9,
   parameter int ADDR_W = 8,
   parameter int NRD    = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr [NRD],
   output logic [DATA_W-1:0] o_rd_data [NRD]
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Out-of-range write addresses are dropped rather than aliased onto a slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int n = 0; n < DEPTH; n++) begin
            r_mem[n] <= '0;
         end
      end else if (i_wr_en && (i_wr_addr < ADDR_W'(DEPTH))) begin
         r_mem[i_wr_addr[IDX_W-1:0]] <= i_wr_data;
      end
   end

   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         o_rd_data[p] = '0;
         if (i_rd_addr[p] < ADDR_W'(DEPTH)) begin
            o_rd_data[p] = r_mem[i_rd_addr[p][IDX_W-1:0]];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one A and one B tile and streams them skewed into an NxN systolic array.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N      = 3,
   parameter int K      = 3,
   parameter int ADDR_W = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_wr_en,
   input  logic                i_wr_sel,
   input  logic [ADDR_W-1:0]   i_wr_addr,
   input  logic [DATA_W-1:0]   i_wr_data,
   input  logic                i_start,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_pe_clear,
   output logic [N*DATA_W-1:0] o_a_edge,
   output logic [N*DATA_W-1:0] o_b_edge
);

   localparam int DEPTH = N * K;
   localparam int T_W   = $clog2(K + N);
   localparam logic [T_W-1:0] T_STREAM_LAST = T_W'(K + N - 2);
   localparam logic [T_W-1:0] T_DRAIN_LAST  = T_W'(N - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [T_W-1:0]      r_t;
   logic [T_W-1:0]      w_next_t;
   logic                w_wr_ok;
   logic [N-1:0]        w_lane_valid;
   logic [ADDR_W-1:0]   w_a_addr [N];
   logic [ADDR_W-1:0]   w_b_addr [N];
   logic [DATA_W-1:0]   w_a_data [N];
   logic [DATA_W-1:0]   w_b_data [N];
   logic [N*DATA_W-1:0] w_a_next;
   logic [N*DATA_W-1:0] w_b_next;
   logic                r_busy;
   logic                r_done;
   logic                r_pe_clear;
   logic [N*DATA_W-1:0] r_a_edge;
   logic [N*DATA_W-1:0] r_b_edge;

   assign w_wr_ok = i_wr_en && (r_state == IDLE);

   operand_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NRD    (N)
   ) u_buf_a (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (w_wr_ok && (i_wr_sel == WSEL_A)),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_rd_addr (w_a_addr),
      .o_rd_data (w_a_data)
   );

   operand_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NRD    (N)
   ) u_buf_b (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (w_wr_ok && (i_wr_sel == WSEL_B)),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_rd_addr (w_b_addr),
      .o_rd_data (w_b_data)
   );

   // t doubles as the drain-cycle counter; it restarts at 0 on every phase change.
   always_comb begin
      w_next_state = r_state;
      w_next_t     = r_t;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next_state = CLEAR;
               w_next_t     = '0;
            end
         end
         CLEAR: begin
            w_next_state = STREAM;
            w_next_t     = '0;
         end
         STREAM: begin
            if (r_t == T_STREAM_LAST) begin
               w_next_state = DRAIN;
               w_next_t     = '0;
            end else begin
               w_next_t = r_t + 1'b1;
            end
         end
         DRAIN: begin
            if (r_t == T_DRAIN_LAST) begin
               w_next_state = DONE;
               w_next_t     = '0;
            end else begin
               w_next_t = r_t + 1'b1;
            end
         end
         DONE: begin
            w_next_state = IDLE;
            w_next_t     = '0;
         end
         default: begin
            w_next_state = IDLE;
            w_next_t     = '0;
         end
      endcase
   end

   // Lane l carries element (t-l) of its row/column; the skew is the lane offset.
   always_comb begin
      w_lane_valid = '0;
      for (int l = 0; l < N; l++) begin
         w_a_addr[l] = '0;
         w_b_addr[l] = '0;
         if ((w_next_state == STREAM) && (int'(w_next_t) >= l) && (int'(w_next_t) < l + K)) begin
            w_lane_valid[l] = 1'b1;
            w_a_addr[l]     = ADDR_W'(l * K + int'(w_next_t) - l);
            w_b_addr[l]     = ADDR_W'((int'(w_next_t) - l) * N + l);
         end
      end
   end

   always_comb begin
      w_a_next = '0;
      w_b_next = '0;
      for (int l = 0; l < N; l++) begin
         if (w_lane_valid[l]) begin
            w_a_next[l*DATA_W +: DATA_W] = w_a_data[l];
            w_b_next[l*DATA_W +: DATA_W] = w_b_data[l];
         end
      end
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_t        <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pe_clear <= 1'b0;
         r_a_edge   <= '0;
         r_b_edge   <= '0;
      end else begin
         r_state    <= w_next_state;
         r_t        <= w_next_t;
         r_busy     <= (w_next_state != IDLE);
         r_done     <= (w_next_state == DONE);
         r_pe_clear <= (w_next_state == CLEAR);
         r_a_edge   <= w_a_next;
         r_b_edge   <= w_b_next;
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_pe_clear = r_pe_clear;
   assign o_a_edge   = r_a_edge;
   assign o_b_edge   = r_b_edge;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder driving a behavioural 3x3 PE grid.
module tb_systolic_feeder;

   typedef struct packed {
      logic        clr;
      logic        dn;
      logic [23:0] a;
      logic [23:0] b;
   } expT;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrEn;
   logic        wrSel;
   logic [7:0]  wrAddr;
   logic [7:0]  wrData;
   logic        start;
   logic        busy;
   logic        done;
   logic        peClear;
   logic [23:0] aEdge;
   logic [23:0] bEdge;

   int testsRun  = 0;
   int failures  = 0;
   int doneCount = 0;

   expT expQ [$];
   int  resQ [$];
   expT expCur;

   // Hand-derived skew table for A = 1..9, B = {9,8,7;3,2,1;8,9,2}; index [t][lane].
   int skewA [5][3] = '{'{1,0,0}, '{2,4,0}, '{3,5,7}, '{0,6,8}, '{0,0,9}};
   int skewB [5][3] = '{'{9,0,0}, '{3,8,0}, '{8,2,7}, '{0,9,1}, '{0,0,2}};
   int tileB [9]    = '{9, 8, 7, 3, 2, 1, 8, 9, 2};
   int expC  [9]    = '{39, 39, 15, 99, 96, 45, 159, 153, 75};

   logic [7:0] peA   [3][3] = '{default: '0};
   logic [7:0] peB   [3][3] = '{default: '0};
   logic [7:0] peOut [3][3] = '{default: '0};
   logic [7:0] aInM  [3][3];
   logic [7:0] bInM  [3][3];

   systolic_feeder dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_en    (wrEn),
      .i_wr_sel   (wrSel),
      .i_wr_addr  (wrAddr),
      .i_wr_data  (wrData),
      .i_start    (start),
      .o_busy     (busy),
      .o_done     (done),
      .o_pe_clear (peClear),
      .o_a_edge   (aEdge),
      .o_b_edge   (bEdge)
   );

   always #5 clk = ~clk;

   // Behavioural PE grid: a moves right, b moves down, out accumulates mod 256.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         aInM[i][0] = aEdge[i*8 +: 8];
         bInM[0][i] = bEdge[i*8 +: 8];
         for (int j = 1; j < 3; j++) begin
            aInM[i][j] = peA[i][j-1];
            bInM[j][i] = peB[j-1][i];
         end
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            peA[i][j]   <= aInM[i][j];
            peB[i][j]   <= bInM[i][j];
            peOut[i][j] <= peClear ? 8'd0 : 8'(peOut[i][j] + 8'(aInM[i][j] * bInM[i][j]));
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic sel, input logic [7:0] addr,
                                input logic [7:0] data, input logic st);
      @(posedge clk);
      #1;
      wrEn   = we;
      wrSel  = sel;
      wrAddr = addr;
      wrData = data;
      start  = st;
   endtask

   task automatic pushTile(input bit zeroTile);
      expT e;
      e = '{clr: 1'b1, dn: 1'b0, a: '0, b: '0};
      expQ.push_back(e);
      for (int t = 0; t < 5; t++) begin
         e = '{clr: 1'b0, dn: 1'b0, a: '0, b: '0};
         if (!zeroTile) begin
            for (int l = 0; l < 3; l++) begin
               e.a[l*8 +: 8] = 8'(skewA[t][l]);
               e.b[l*8 +: 8] = 8'(skewB[t][l]);
            end
         end
         expQ.push_back(e);
      end
      for (int d = 0; d < 3; d++) begin
         e = '{clr: 1'b0, dn: 1'b0, a: '0, b: '0};
         expQ.push_back(e);
      end
      e = '{clr: 1'b0, dn: 1'b1, a: '0, b: '0};
      expQ.push_back(e);
      for (int n = 0; n < 9; n++) begin
         resQ.push_back(zeroTile ? 0 : expC[n]);
      end
   endtask

   task automatic waitIdle();
      int n = 0;
      do begin
         applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
         n++;
      end while (busy && n < 40);
      if (busy) checkOutput("tile completion timeout busy", {63'd0, busy}, 64'd0);
   endtask

   // Monitor: every busy cycle consumes one expected output; done also checks the PE grid.
   always @(negedge clk) begin
      if (busy) begin
         if (expQ.size() == 0) begin
            checkOutput("busy beyond expected tile", {63'd0, busy}, 64'd0);
         end else begin
            expCur = expQ.pop_front();
            checkOutput("pe_clear/done", {62'd0, peClear, done}, {62'd0, expCur.clr, expCur.dn});
            checkOutput("a_edge", {40'd0, aEdge}, {40'd0, expCur.a});
            checkOutput("b_edge", {40'd0, bEdge}, {40'd0, expCur.b});
         end
      end else begin
         checkOutput("idle outputs", {14'd0, done, peClear, aEdge, bEdge}, 64'd0);
      end
      if (done) begin
         doneCount++;
         for (int n = 0; n < 9; n++) begin
            if (resQ.size() == 0) begin
               checkOutput("unexpected done", {63'd0, done}, 64'd0);
            end else begin
               checkOutput($sformatf("PE(%0d,%0d) out", n / 3, n % 3),
                           {56'd0, peOut[n/3][n%3]}, 64'(resQ.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst    = 1'b1;
      wrEn   = 1'b0;
      wrSel  = 1'b0;
      wrAddr = '0;
      wrData = '0;
      start  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", {63'd0, busy}, 64'd0);
      checkOutput("reset outputs", {14'd0, done, peClear, aEdge, bEdge}, 64'd0);
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      rst = 1'b0;

      for (int n = 0; n < 9; n++) applyStimulus(1'b1, 1'b0, 8'(n), 8'(n + 1), 1'b0);
      for (int n = 0; n < 9; n++) applyStimulus(1'b1, 1'b1, 8'(n), 8'(tileB[n]), 1'b0);

      // Tile 1: skew and handshake, with a write and a second start landing mid-tile.
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
      pushTile(1'b0);
      repeat (4) applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'd0, 8'hFF, 1'b1);
      waitIdle();

      // Tile 2: out-of-range write is dropped and the buffers still hold the first tile.
      applyStimulus(1'b1, 1'b0, 8'd9, 8'h55, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'd9, 8'h66, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
      pushTile(1'b0);
      waitIdle();

      // Tile 3: aborted by an asynchronous reset in the middle of DRAIN.
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
      pushTile(1'b0);
      repeat (8) applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      #2;
      rst = 1'b1;
      expQ.delete();
      resQ.delete();
      #1;
      checkOutput("abort busy", {63'd0, busy}, 64'd0);
      checkOutput("abort outputs", {14'd0, done, peClear, aEdge, bEdge}, 64'd0);
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      rst = 1'b0;

      // Tile 4: cleared buffers stream zeros and every PE ends at 0.
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
      pushTile(1'b1);
      waitIdle();

      repeat (2) applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      checkOutput("done pulse count", 64'(doneCount), 64'd3);
      checkOutput("leftover stream expectations", 64'(expQ.size()), 64'd0);
      checkOutput("leftover result expectations", 64'(resQ.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
